// File: rtl/input_debounce_if.sv
// Signal bundle between raw switch/button inputs and the debounce stage.
// any_edge qualifies rise/fall; there is no back-pressure, so a consumer must
// take rise/fall in the single cycle that any_edge is high.
interface input_debounce_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_edge;

  modport master (
    output raw_in,
    input  stable,
    input  rise,
    input  fall,
    input  any_edge
  );

  modport slave (
    input  raw_in,
    output stable,
    output rise,
    output fall,
    output any_edge
  );
endinterface

// File: rtl/input_debounce.sv
// Per-channel 2-flop synchronizer, counter debounce and registered edge strobes.
// Every output is driven straight from a flop; raw_in only reaches the sync chain.
module input_debounce #(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  input_debounce_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         r_sync1;
  logic [WIDTH-1:0]         r_sync2;
  logic [WIDTH-1:0]         r_stable;
  logic [WIDTH-1:0]         r_rise;
  logic [WIDTH-1:0]         r_fall;
  logic                     r_any_edge;
  logic [WIDTH-1:0][CW-1:0] r_cnt;

  logic [WIDTH-1:0]         w_differ;
  logic [WIDTH-1:0]         w_accept;

  // A channel accepts its new level on the cycle its count reaches the last value
  // while the synchronized input still disagrees with the stable level.
  always_comb begin
    w_differ = r_sync2 ^ r_stable;
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_differ[i] && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Any return to agreement, or an acceptance, restarts the count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_differ[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable   <= RESET_VAL;
      r_rise     <= '0;
      r_fall     <= '0;
      r_any_edge <= 1'b0;
    end else begin
      r_stable   <= (r_stable & ~w_accept) | (r_sync2 & w_accept);
      r_rise     <= w_accept & r_sync2;
      r_fall     <= w_accept & ~r_sync2;
      r_any_edge <= |w_accept;
    end
  end

  assign bus.stable   = r_stable;
  assign bus.rise     = r_rise;
  assign bus.fall     = r_fall;
  assign bus.any_edge = r_any_edge;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEBOUNCE_CYCLES = 4; expected edge
// events carry the cycle they must appear on and are matched by a monitor.
module tb_input_debounce;

  localparam int W   = 2;
  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  input_debounce_if #(.WIDTH(W)) bus ();

  input_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .RESET_VAL       (2'b00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // {cycle, stable, rise, fall}
  logic [37:0] exp_q[$];
  logic [37:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_edge(input logic [1:0] st, input logic [1:0] r, input logic [1:0] f,
                             input int unsigned delay);
    exp_q.push_back({cyc + delay, st, r, f});
  endtask

  // scoreboard monitor: any_edge is the output strobe
  always @(negedge clk) begin
    if (bus.any_edge) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_edge: got stable=%b rise=%b fall=%b expected no event (cycle %0d)",
                 bus.stable, bus.rise, bus.fall, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("edge_cycle",  cyc,                mon_e[37:6]);
        check("edge_stable", {30'd0, bus.stable}, {30'd0, mon_e[5:4]});
        check("edge_rise",   {30'd0, bus.rise},   {30'd0, mon_e[3:2]});
        check("edge_fall",   {30'd0, bus.fall},   {30'd0, mon_e[1:0]});
      end
    end else begin
      check("idle_pulses", {28'd0, bus.rise, bus.fall}, 32'd0);
    end
  end

  logic [6:0] pat;

  initial begin
    // 1: reset with both inputs high, then release
    rst = 1'b1;
    bus.raw_in = 2'b11;
    tick(3);
    check("rst_stable",   {30'd0, bus.stable},   32'd0);
    check("rst_pulses",   {28'd0, bus.rise, bus.fall}, 32'd0);
    check("rst_any_edge", {31'd0, bus.any_edge}, 32'd0);
    rst = 1'b0;
    expect_edge(2'b11, 2'b11, 2'b00, LAT);
    tick(LAT + 3);
    check("t1_stable", {30'd0, bus.stable}, 32'd3);

    // 5: both channels fall together
    bus.raw_in = 2'b00;
    expect_edge(2'b00, 2'b00, 2'b11, LAT);
    tick(LAT + 3);
    check("t5_stable", {30'd0, bus.stable}, 32'd0);

    // 3: three-cycle glitch on channel 0 is rejected
    bus.raw_in = 2'b01;
    tick(3);
    bus.raw_in = 2'b00;
    tick(10);
    check("t3_stable", {30'd0, bus.stable}, 32'd0);

    // 2: clean rise on channel 0
    bus.raw_in = 2'b01;
    expect_edge(2'b01, 2'b01, 2'b00, LAT);
    tick(LAT - 1);
    check("t2_before", {30'd0, bus.stable}, 32'd0);
    tick(4);
    check("t2_stable", {30'd0, bus.stable}, 32'd1);

    // 4: bounce 1,1,0,1,1,1,1 on channel 1, timed from the last 0->1
    pat = 7'b1101111;
    for (int i = 0; i < 7; i++) begin
      bus.raw_in[1] = pat[6-i];
      if (i == 3) expect_edge(2'b11, 2'b10, 2'b00, LAT);
      tick(1);
    end
    tick(8);
    check("t4_stable", {30'd0, bus.stable}, 32'd3);

    // 6: asynchronous reset mid-count (cnt = 2) on a pending channel 0 fall
    bus.raw_in = 2'b10;
    tick(4);
    #2 rst = 1'b1;
    #1;
    check("t6_async_stable",   {30'd0, bus.stable},   32'd0);
    check("t6_async_pulses",   {28'd0, bus.rise, bus.fall}, 32'd0);
    check("t6_async_any_edge", {31'd0, bus.any_edge}, 32'd0);
    tick(2);
    rst = 1'b0;
    expect_edge(2'b10, 2'b10, 2'b00, LAT);
    tick(LAT + 3);
    check("t6_stable", {30'd0, bus.stable}, 32'd2);

    // final report
    tick(5);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
Input conditioning stage directly upstream of the NPC top-level logic. Takes raw, asynchronous switch/button inputs and, per channel, performs:
- 2-flop synchronization
- counter-based debounce
- rising/falling edge detection

The clean stable[] bits drive the top-level a/b operand inputs; the edge pulses serve as single-cycle event strobes. Purely synchronous to clk except the asynchronous reset.

Parameters:
WIDTH, 2, number of independent input channels
DEBOUNCE_CYCLES, 50000, consecutive synchronized cycles a new level must hold before it is accepted (legal range >= 1; benches use 4)
RESET_VAL, {WIDTH{1'b0}}, reset value of sync flops and stable outputs

Ports:
clk  input  1  single clock for all state
rst  input  1  asynchronous, active-high reset
raw_in  input  WIDTH  raw asynchronous inputs (switches/buttons)
stable  output  WIDTH  debounced level per channel
rise  output  WIDTH  one-cycle pulse when stable[i] goes 0->1
fall  output  WIDTH  one-cycle pulse when stable[i] goes 1->0
any_edge  output  1  OR-reduction of rise|fall, registered with them

Behaviour:
Reset:
- Reset is asynchronous on rst high.
- Clears: sync1 = sync2 = RESET_VAL; stable = RESET_VAL; all counters 0; rise = fall = 0; any_edge = 0.
- Deassertion is sampled on the next clk edge. No spurious pulses after reset, since sync and stable share the same reset value.

Synchronizer:
- Per channel: sync1 <= raw_in; sync2 <= sync1.
- Only sync2 is used downstream.

Counter:
- One per channel, width max(1, clog2(DEBOUNCE_CYCLES)).
- Saturation is never reached.

Per-channel rule, evaluated each rising edge:
- sync2 == stable: cnt <= 0.
- sync2 != stable and cnt == DEBOUNCE_CYCLES-1:
  - stable <= sync2
  - cnt <= 0
  - rise/fall asserted for this one cycle, coincident with the new stable value
- sync2 != stable otherwise: cnt <= cnt + 1.

Pulses:
- rise, fall and any_edge are registered.
- They are high for exactly one cycle per accepted transition; otherwise 0.

Latency:
- Raw level change set up before edge E0 and held: stable updates at edge E0 + DEBOUNCE_CYCLES + 1.
- Example: DEBOUNCE_CYCLES = 4 gives an update at the 6th edge counting E0.
- With DEBOUNCE_CYCLES = 1, the update is at E0 + 2.

Glitch rejection:
- Any excursion of sync2 lasting fewer than DEBOUNCE_CYCLES cycles returns cnt to 0 and changes nothing.
- A bounce mid-count restarts the count from 0.

Channel independence:
- Channels are fully independent; simultaneous transitions on several channels each produce their own pulses in the same cycle.
- any_edge is high if any channel pulses.

Reset mid-count:
- Aborts the count; no pulse is emitted.
- After release, the debounce restarts from RESET_VAL.

Structural rules:
- No combinational path from raw_in to any output.
- All outputs come directly from flops.

Test Plan:
1. Reset with raw_in = 2'b11 held: stable = 0, rise = fall = 0 during reset. After release, stable[1:0] = 2'b11 at the 6th edge (DEBOUNCE_CYCLES = 4), with rise = 2'b11 and any_edge = 1 for exactly one cycle.
2. raw_in[0] 0->1 held, DEBOUNCE_CYCLES = 4: stable[0] rises exactly 6 edges after the first sampling edge; rise[0] is a single 1-cycle pulse; fall = 0.
3. raw_in[0] glitch high for 3 cycles, then low: stable[0] stays 0, no pulses, internal count returns to 0.
4. Bounce pattern 1,1,0,1,1,1,1 on raw_in[1] with stable[1] = 0: acceptance is measured from the last 0->1 only; a single rise[1] pulse occurs.
5. stable = 2'b11, then raw_in -> 2'b00 simultaneously: fall = 2'b11 in the same cycle, any_edge = 1 for one cycle, stable = 2'b00.
6. rst asserted asynchronously (between edges) during a count at cnt = 2: stable and pulses clear immediately. The pending transition is not emitted and completes only after a full re-count following release.
